// File: rtl/speed2phase.sv
// Doppler stimulus generator: turns a 6Q10 target speed into a burst of 2^N
// identical 9Q10 phase-difference samples, optionally dithered by +/-1 LSB.
module speed2phase #(
    parameter int unsigned KINV   = 26253,
    parameter int unsigned DIV    = 4,
    parameter bit          DITHER = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    input  logic [3:0]  n_i,
    input  logic [15:0] in_speed_i,
    input  logic        speed_valid_i,
    output logic        speed_ready_o,
    output logic [18:0] out_phasediff_o,
    output logic        data_rdy_o,
    output logic        burst_done_o
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    localparam logic [16:0] KINV_C = 17'(KINV);
    localparam logic [7:0]  DIV_M1 = 8'(DIV - 1);

    state_t             state_q, state_d;
    logic signed [15:0] speed_q, speed_d;
    logic        [3:0]  n_q, n_d;
    logic signed [18:0] pd_q, pd_d;
    logic        [10:0] cnt_q, cnt_d;
    logic        [7:0]  div_q, div_d;
    logic        [15:0] lfsr_q, lfsr_d;
    logic signed [18:0] out_q, out_d;
    logic               rdy_q, rdy_d;
    logic               done_q, done_d;

    logic signed [33:0] prod;
    logic signed [33:0] rounded;
    logic signed [21:0] pd_wide;
    logic signed [18:0] pd_sat;
    logic signed [1:0]  dither;
    logic signed [19:0] dsum;
    logic signed [18:0] dith_sat;
    logic               lfsr_fb;

    // Round-half-up then arithmetic shift; the product fits easily in 34 bits.
    always_comb begin
        prod    = $signed({{18{speed_q[15]}}, speed_q}) * $signed({17'd0, KINV_C});
        rounded = prod + 34'sd2048;
        pd_wide = 22'(rounded >>> 12);
        if (pd_wide > 22'sd262143) begin
            pd_sat = 19'sd262143;
        end else if (pd_wide < -22'sd262144) begin
            pd_sat = -19'sd262144;
        end else begin
            pd_sat = pd_wide[18:0];
        end
    end

    always_comb begin
        lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        dither  = 2'sd0;
        if (DITHER) begin
            case (lfsr_q[1:0])
                2'b00:   dither = -2'sd1;
                2'b11:   dither = 2'sd1;
                default: dither = 2'sd0;
            endcase
        end
        dsum = {pd_q[18], pd_q} + {{18{dither[1]}}, dither};
        if (dsum > 20'sd262143) begin
            dith_sat = 19'sd262143;
        end else if (dsum < -20'sd262144) begin
            dith_sat = -19'sd262144;
        end else begin
            dith_sat = dsum[18:0];
        end
    end

    always_comb begin
        state_d = state_q;
        speed_d = speed_q;
        n_d     = n_q;
        pd_d    = pd_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        lfsr_d  = lfsr_q;
        out_d   = out_q;
        rdy_d   = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (speed_valid_i) begin
                    speed_d = in_speed_i;
                    n_d     = (n_i > 4'd11) ? 4'd11 : n_i;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pd_d    = pd_sat;
                cnt_d   = (11'd1 << n_q) - 11'd1;
                div_d   = 8'd0;
                state_d = RUN;
            end
            RUN: begin
                if (en_i) begin
                    if (div_q == 8'd0) begin
                        rdy_d  = 1'b1;
                        out_d  = dith_sat;
                        lfsr_d = {lfsr_fb, lfsr_q[15:1]};
                        div_d  = DIV_M1;
                        // The strobe taken with the counter at zero closes the burst.
                        if (cnt_q == 11'd0) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q - 11'd1;
                        end
                    end else begin
                        div_d = div_q - 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            speed_q <= '0;
            n_q     <= '0;
            pd_q    <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
            lfsr_q  <= 16'hACE1;
            out_q   <= '0;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            speed_q <= speed_d;
            n_q     <= n_d;
            pd_q    <= pd_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            lfsr_q  <= lfsr_d;
            out_q   <= out_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
        end
    end

    assign speed_ready_o   = (state_q == IDLE);
    assign out_phasediff_o = out_q;
    assign data_rdy_o      = rdy_q;
    assign burst_done_o    = done_q;

endmodule

// File: tb/tb_speed2phase.sv
// Self-checking bench for speed2phase: two instances (plain DIV=4, and
// DIV=1 with dither at the high KINV) checked against an arithmetic model.
module tb_speed2phase;

    localparam int KINV_A = 26253;
    localparam int DIV_A  = 4;
    localparam int KINV_B = 33265;
    localparam int DIV_B  = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  nIn;
    logic [15:0] speedIn;
    logic        validIn [2];
    logic        readyOut [2];
    logic [18:0] pdOut [2];
    logic        rdyOut [2];
    logic        doneOut [2];

    int compared   = 0;
    int mismatched = 0;

    int kinvTab [2] = '{KINV_A, KINV_B};
    int divTab  [2] = '{DIV_A, DIV_B};
    int dithTab [2] = '{0, 1};

    int expVal [2];
    int lfsrModel;
    int minSeen1;
    int maxSeen1;
    int strobeEdges1 [$];

    always #5 clk = ~clk;

    speed2phase #(.KINV(KINV_A), .DIV(DIV_A), .DITHER(1'b0)) dutA (
        .clk(clk), .reset(reset), .en_i(en), .n_i(nIn), .in_speed_i(speedIn),
        .speed_valid_i(validIn[0]), .speed_ready_o(readyOut[0]),
        .out_phasediff_o(pdOut[0]), .data_rdy_o(rdyOut[0]), .burst_done_o(doneOut[0])
    );

    speed2phase #(.KINV(KINV_B), .DIV(DIV_B), .DITHER(1'b1)) dutB (
        .clk(clk), .reset(reset), .en_i(en), .n_i(nIn), .in_speed_i(speedIn),
        .speed_valid_i(validIn[1]), .speed_ready_o(readyOut[1]),
        .out_phasediff_o(pdOut[1]), .data_rdy_o(rdyOut[1]), .burst_done_o(doneOut[1])
    );

    function automatic int floorDiv4096(longint num);
        if (num >= 0) return int'(num / 4096);
        return -int'((-num + 4095) / 4096);
    endfunction

    function automatic int clampPd(longint v);
        if (v > 262143) return 262143;
        if (v < -262144) return -262144;
        return int'(v);
    endfunction

    function automatic int refPd(int spd, int d);
        longint prod;
        prod = longint'(spd) * longint'(kinvTab[d]);
        return clampPd(floorDiv4096(prod + 2048));
    endfunction

    // Returns the dither for the current LFSR state, then steps the LFSR once.
    function automatic int ditherStep();
        int low;
        int fb;
        low = lfsrModel % 4;
        fb = ((lfsrModel >> 0) ^ (lfsrModel >> 2) ^ (lfsrModel >> 3) ^ (lfsrModel >> 5)) & 1;
        lfsrModel = (lfsrModel >> 1) | (fb << 15);
        return (low == 0) ? -1 : ((low == 3) ? 1 : 0);
    endfunction

    function automatic int sval(logic [18:0] v);
        return int'($signed(v));
    endfunction

    task automatic run_burst(input int spd, input int nv, input int gapStart, input int gapLen);
        int  nEff, total, budget;
        int  pdv [2];
        int  cnt [2];
        int  j [2];
        bit  fin [2];
        nEff   = (nv > 11) ? 11 : nv;
        total  = 1 << nEff;
        budget = 4 + total * DIV_A + gapLen + 8;
        strobeEdges1.delete();
        minSeen1 = 2147483647;
        maxSeen1 = -2147483647;
        for (int d = 0; d < 2; d++) begin
            pdv[d] = refPd(spd, d);
            cnt[d] = 0;
            j[d]   = 0;
            fin[d] = 1'b0;
        end
        speedIn    = spd[15:0];
        nIn        = nv[3:0];
        validIn[0] = 1'b1;
        validIn[1] = 1'b1;
        en         = 1'b1;
        @(posedge clk); #1;
        validIn[0] = 1'b0;
        validIn[1] = 1'b0;
        speedIn    = 16'($urandom);
        nIn        = 4'($urandom);
        for (int d = 0; d < 2; d++) begin
            compared++;
            if (readyOut[d] !== 1'b0 || rdyOut[d] !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL load_state dut%0d: ready=%b rdy=%b, required 0 0", d, readyOut[d], rdyOut[d]);
            end
        end
        for (int e = 1; e <= budget && !(fin[0] && fin[1]); e++) begin
            en = (e >= gapStart && e < gapStart + gapLen) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                bit expStrobe;
                bit expDone;
                expStrobe = 1'b0;
                expDone   = 1'b0;
                if (!fin[d] && e >= 2 && en) begin
                    if (j[d] % divTab[d] == 0) begin
                        expStrobe = 1'b1;
                        cnt[d]++;
                        expVal[d] = (dithTab[d] != 0) ? clampPd(longint'(pdv[d]) + ditherStep()) : pdv[d];
                        if (cnt[d] == total) begin
                            expDone = 1'b1;
                            fin[d]  = 1'b1;
                        end
                    end
                    j[d]++;
                end
                compared++;
                if (rdyOut[d] !== expStrobe) begin
                    mismatched++;
                    $display("[TB] FAIL data_rdy dut%0d edge %0d: got %b, required %b", d, e, rdyOut[d], expStrobe);
                end
                compared++;
                if (doneOut[d] !== expDone) begin
                    mismatched++;
                    $display("[TB] FAIL burst_done dut%0d edge %0d: got %b, required %b", d, e, doneOut[d], expDone);
                end
                compared++;
                if (sval(pdOut[d]) !== expVal[d]) begin
                    mismatched++;
                    $display("[TB] FAIL phasediff dut%0d edge %0d: got %0d, required %0d", d, e, sval(pdOut[d]), expVal[d]);
                end
                compared++;
                if (readyOut[d] !== fin[d]) begin
                    mismatched++;
                    $display("[TB] FAIL speed_ready dut%0d edge %0d: got %b, required %b", d, e, readyOut[d], fin[d]);
                end
            end
            if (rdyOut[1] === 1'b1) begin
                strobeEdges1.push_back(e);
                if (sval(pdOut[1]) < minSeen1) minSeen1 = sval(pdOut[1]);
                if (sval(pdOut[1]) > maxSeen1) maxSeen1 = sval(pdOut[1]);
            end
        end
        compared++;
        if (!(fin[0] && fin[1])) begin
            mismatched++;
            $display("[TB] FAIL burst_timeout: finished A=%b B=%b, required 1 1", fin[0], fin[1]);
        end
        en = 1'b1;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        en         = 1'b0;
        validIn[0] = 1'b0;
        validIn[1] = 1'b0;
        nIn        = 4'd0;
        speedIn    = 16'd0;
        lfsrModel  = 32'hACE1;
        expVal[0]  = 0;
        expVal[1]  = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            compared++;
            if (readyOut[d] !== 1'b1 || sval(pdOut[d]) !== 0 || rdyOut[d] !== 1'b0 || doneOut[d] !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL reset_values dut%0d: ready=%b pd=%0d rdy=%b done=%b, required 1 0 0 0",
                         d, readyOut[d], sval(pdOut[d]), rdyOut[d], doneOut[d]);
            end
        end
        reset = 1'b0;
        en    = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                compared++;
                if (rdyOut[d] !== 1'b0 || readyOut[d] !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL idle_quiet dut%0d: rdy=%b ready=%b, required 0 1", d, rdyOut[d], readyOut[d]);
                end
            end
        end
    endtask

    task automatic test_nominal();
        run_burst(1024, 2, 0, 0);
        compared++;
        if (sval(pdOut[0]) !== 6563) begin
            mismatched++;
            $display("[TB] FAIL nominal_value: got %0d, required 6563", sval(pdOut[0]));
        end
    endtask

    task automatic test_single();
        run_burst(-1024, 0, 0, 0);
        compared++;
        if (sval(pdOut[0]) !== -6563) begin
            mismatched++;
            $display("[TB] FAIL single_value: got %0d, required -6563", sval(pdOut[0]));
        end
        compared++;
        if (strobeEdges1.size() != 1 || strobeEdges1[0] != 2) begin
            mismatched++;
            $display("[TB] FAIL single_timing: strobes=%0d, required one at edge 2", strobeEdges1.size());
        end
    endtask

    task automatic test_saturation();
        run_burst(32767, 1, 0, 0);
        compared++;
        if (minSeen1 < 262142 || maxSeen1 > 262143) begin
            mismatched++;
            $display("[TB] FAIL sat_high: range %0d..%0d, required within 262142..262143", minSeen1, maxSeen1);
        end
        run_burst(-32768, 1, 0, 0);
        compared++;
        if (minSeen1 < -262144 || maxSeen1 > -262143) begin
            mismatched++;
            $display("[TB] FAIL sat_low: range %0d..%0d, required within -262144..-262143", minSeen1, maxSeen1);
        end
    endtask

    task automatic test_en_gap();
        run_burst(1500, 3, 5, 5);
        compared++;
        if (strobeEdges1.size() != 8) begin
            mismatched++;
            $display("[TB] FAIL gap_count: got %0d strobes, required 8", strobeEdges1.size());
        end else begin
            compared++;
            if (strobeEdges1[3] - strobeEdges1[2] != 6) begin
                mismatched++;
                $display("[TB] FAIL gap_length: spacing %0d, required 6", strobeEdges1[3] - strobeEdges1[2]);
            end
        end
    endtask

    task automatic test_reset_abort();
        speedIn    = 16'd2000;
        nIn        = 4'd4;
        validIn[0] = 1'b1;
        validIn[1] = 1'b1;
        en         = 1'b1;
        @(posedge clk); #1;
        validIn[0] = 1'b0;
        validIn[1] = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        compared++;
        if (rdyOut[0] !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL abort_second_strobe: got %b, required 1", rdyOut[0]);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        lfsrModel = 32'hACE1;
        expVal[0] = 0;
        expVal[1] = 0;
        for (int d = 0; d < 2; d++) begin
            compared++;
            if (readyOut[d] !== 1'b1 || sval(pdOut[d]) !== 0 || rdyOut[d] !== 1'b0 || doneOut[d] !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL abort_values dut%0d: ready=%b pd=%0d rdy=%b done=%b, required 1 0 0 0",
                         d, readyOut[d], sval(pdOut[d]), rdyOut[d], doneOut[d]);
            end
        end
        reset = 1'b0;
        run_burst(-3000, 1, 0, 0);
    endtask

    task automatic test_back_to_back();
        int pdB;
        bit expStrobe;
        bit expDone;
        pdB        = refPd(500, 1);
        nIn        = 4'd1;
        speedIn    = 16'd500;
        en         = 1'b1;
        validIn[1] = 1'b1;
        // Period is 2 + (2^1 - 1)*1 + 1 = 4 edges; strobes on offsets 2 and 3.
        for (int e = 0; e < 16; e++) begin
            @(posedge clk); #1;
            expStrobe = (e % 4 == 2) || (e % 4 == 3);
            expDone   = (e % 4 == 3);
            if (expStrobe) expVal[1] = clampPd(longint'(pdB) + ditherStep());
            compared++;
            if (rdyOut[1] !== expStrobe || doneOut[1] !== expDone) begin
                mismatched++;
                $display("[TB] FAIL b2b_strobe edge %0d: rdy=%b done=%b, required %b %b", e, rdyOut[1], doneOut[1], expStrobe, expDone);
            end
            compared++;
            if (readyOut[1] !== expDone || sval(pdOut[1]) !== expVal[1]) begin
                mismatched++;
                $display("[TB] FAIL b2b_state edge %0d: ready=%b pd=%0d, required %b %0d", e, readyOut[1], sval(pdOut[1]), expDone, expVal[1]);
            end
            compared++;
            if (rdyOut[0] !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL b2b_other edge %0d: got %b, required 0", e, rdyOut[0]);
            end
        end
        validIn[1] = 1'b0;
    endtask

    task automatic test_dither();
        run_burst(1024, 11, 0, 0);
        compared++;
        if (strobeEdges1.size() != 2048 || minSeen1 < 8315 || maxSeen1 > 8317) begin
            mismatched++;
            $display("[TB] FAIL dither_range: %0d samples in %0d..%0d, required 2048 in 8315..8317",
                     strobeEdges1.size(), minSeen1, maxSeen1);
        end
    endtask

    task automatic test_clamp_n();
        run_burst(-700, 13, 0, 0);
        compared++;
        if (strobeEdges1.size() != 2048) begin
            mismatched++;
            $display("[TB] FAIL n_clamp: got %0d strobes, required 2048", strobeEdges1.size());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_burst(int'($signed(16'($urandom))), int'($urandom_range(0, 4)),
                      int'($urandom_range(2, 12)), int'($urandom_range(0, 4)));
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_single();
        test_saturation();
        test_en_gap();
        test_back_to_back();
        test_reset_abort();
        test_random();
        test_dither();
        test_clamp_n();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
